// File: rtl/v_pkg.sv
// Shared payload types for the List Update Bus.
package v_pkg;

    typedef logic [3:0] id_t;
    typedef logic [1:0] cmd_t;
    typedef logic [7:0] key_t;
    typedef logic [3:0] size_t;

    // One buffered request / one issued update, packed in bus field order.
    typedef struct packed {
        id_t   prod_id;
        cmd_t  cmd;
        key_t  key;
        size_t size;
    } entry_t;

endpackage

// File: rtl/v_upd_issue_if.sv
// Request handshake and update bus bundle for v_upd_issue.
//
// Request side: a request transfers on a rising clock edge where
// i_req_vld && o_req_rdy. The producer holds payload stable while
// i_req_vld is high and not yet accepted; o_req_rdy never depends on
// i_req_vld. The update side is valid-only: o_upd_vld_r is a one-cycle
// pulse per update and the consumer cannot stall it.
interface v_upd_issue_if #(
    parameter int FIFO_DEPTH = 4
) ();
    localparam int LW = $clog2(FIFO_DEPTH + 1);

    logic          i_req_vld;
    v_pkg::id_t    i_req_prod_id;
    v_pkg::cmd_t   i_req_cmd;
    v_pkg::key_t   i_req_key;
    v_pkg::size_t  i_req_size;
    logic          o_req_rdy;
    logic          i_upd_hold;
    logic          o_upd_vld_r;
    v_pkg::id_t    o_upd_prod_id_r;
    v_pkg::cmd_t   o_upd_cmd_r;
    v_pkg::key_t   o_upd_key_r;
    v_pkg::size_t  o_upd_size_r;
    logic [LW-1:0] o_level_r;
    logic          o_empty;

    modport master (
        output i_req_vld, i_req_prod_id, i_req_cmd, i_req_key, i_req_size,
        output i_upd_hold,
        input  o_req_rdy, o_upd_vld_r, o_upd_prod_id_r, o_upd_cmd_r,
        input  o_upd_key_r, o_upd_size_r, o_level_r, o_empty
    );

    modport slave (
        input  i_req_vld, i_req_prod_id, i_req_cmd, i_req_key, i_req_size,
        input  i_upd_hold,
        output o_req_rdy, o_upd_vld_r, o_upd_prod_id_r, o_upd_cmd_r,
        output o_upd_key_r, o_upd_size_r, o_level_r, o_empty
    );
endinterface

// File: rtl/v_upd_issue.sv
// Update issuer: buffers accepted requests in a FIFO and issues them onto
// the valid-only update bus with a programmable minimum spacing and hold.
module v_upd_issue #(
    parameter int FIFO_DEPTH = 4,
    parameter int ISSUE_GAP  = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    v_upd_issue_if.slave bus
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int LW = $clog2(FIFO_DEPTH + 1);
    localparam int GW = (ISSUE_GAP > 1) ? $clog2(ISSUE_GAP) : 1;

    localparam logic [LW-1:0] FULL_LVL = LW'(FIFO_DEPTH);
    localparam logic [GW-1:0] GAP_LOAD = GW'(ISSUE_GAP - 1);

    v_pkg::entry_t mem [FIFO_DEPTH];
    v_pkg::entry_t wdata;
    v_pkg::entry_t head;
    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr;
    logic [LW-1:0] level;
    logic [GW-1:0] gap_cnt;
    logic          rdy;
    logic          push;
    logic          issue;

    // Ready comes from the registered level only, so a slot freed by an
    // issue is offered to the producer one cycle later.
    assign rdy   = (level != FULL_LVL);
    assign push  = bus.i_req_vld && rdy;
    assign issue = (level != '0) && (gap_cnt == '0) && !bus.i_upd_hold;

    assign wdata = '{prod_id: bus.i_req_prod_id, cmd: bus.i_req_cmd,
                     key: bus.i_req_key, size: bus.i_req_size};
    assign head  = mem[rptr];

    assign bus.o_req_rdy = rdy;
    assign bus.o_level_r = level;
    assign bus.o_empty   = (level == '0);

    // Storage array: no reset needed, stale entries are unreachable once
    // the pointers and level are cleared.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr] <= wdata;
        end
    end

    // Pointers and occupancy; simultaneous push and issue leave level unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
        end else begin
            if (push) begin
                wptr <= wptr + PW'(1);
            end
            if (issue) begin
                rptr <= rptr + PW'(1);
            end
            unique case ({push, issue})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

    // Spacing counter: reloaded on issue, counts down regardless of hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gap_cnt <= '0;
        end else if (issue) begin
            gap_cnt <= GAP_LOAD;
        end else if (gap_cnt != '0) begin
            gap_cnt <= gap_cnt - GW'(1);
        end
    end

    // Update bus registers: valid pulses for one cycle, payload holds the
    // last issued value between pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.o_upd_vld_r     <= 1'b0;
            bus.o_upd_prod_id_r <= '0;
            bus.o_upd_cmd_r     <= '0;
            bus.o_upd_key_r     <= '0;
            bus.o_upd_size_r    <= '0;
        end else begin
            bus.o_upd_vld_r <= issue;
            if (issue) begin
                bus.o_upd_prod_id_r <= head.prod_id;
                bus.o_upd_cmd_r     <= head.cmd;
                bus.o_upd_key_r     <= head.key;
                bus.o_upd_size_r    <= head.size;
            end
        end
    end

endmodule

// File: doc/v_upd_issue.md
# v_upd_issue

Front-end issuer for the List Update Bus. Accepts update requests from a producer-side client over a valid/ready handshake, buffers them in a small FIFO, and drives them onto the valid-only update bus consumed by the update pipeline. The update bus has no backpressure and the pipeline performs a read-modify-write of shared state, so this block enforces a programmable minimum spacing between issued updates and supports an external hold.

## Interface

Parameters:
- FIFO_DEPTH, 4, request buffer entries; power of two, >= 2
- ISSUE_GAP, 3, minimum cycles between consecutive issued updates; >= 1 (1 = back-to-back)

Ports:
- clk  in  1  clock; all state on rising edge
- rst_n  in  1  reset, asynchronous assert, active-low
- i_req_vld  in  1  request valid
- i_req_prod_id  in  v_pkg::id_t  producer ID
- i_req_cmd  in  v_pkg::cmd_t  update command
- i_req_key  in  v_pkg::key_t  key
- i_req_size  in  v_pkg::size_t  size
- o_req_rdy  out  1  request accepted when i_req_vld && o_req_rdy
- i_upd_hold  in  1  inhibit issue this cycle
- o_upd_vld_r  out  1  update bus valid, one-cycle pulse per update
- o_upd_prod_id_r  out  v_pkg::id_t  update bus producer ID
- o_upd_cmd_r  out  v_pkg::cmd_t  update bus command
- o_upd_key_r  out  v_pkg::key_t  update bus key
- o_upd_size_r  out  v_pkg::size_t  update bus size
- o_level_r  out  $clog2(FIFO_DEPTH+1)  FIFO occupancy
- o_empty  out  1  o_level_r == 0

## Operation

- FIFO: write/read pointers of $clog2(FIFO_DEPTH) bits, wrap modulo FIFO_DEPTH; separate level counter.
- o_req_rdy = (o_level_r != FIFO_DEPTH); combinational from level only, never from i_req_vld.
- Push: i_req_vld && o_req_rdy writes {prod_id, cmd, key, size} at wptr, wptr++.
- Issue condition (cycle t): !o_empty && gap_cnt == 0 && !i_upd_hold.
- On issue: head entry loaded into o_upd_*_r payload registers, o_upd_vld_r = 1 at t+1, rptr++, gap_cnt loaded with ISSUE_GAP-1.
- gap_cnt decrements by 1 each cycle while nonzero; not affected by i_upd_hold.
- Push and issue in same cycle: level unchanged; both pointers advance.
- Full: no push accepted; a same-cycle issue frees a slot but o_req_rdy rises only the following cycle (no pass-through).
- Empty: no issue; no bypass of the FIFO.
- Payload registers load only on issue; hold last issued value while o_upd_vld_r = 0.
- Order preserved: updates issued strictly in acceptance order.

## Timing

- Reset (rst_n low, asynchronous): o_upd_vld_r = 0, all o_upd_*_r payload = 0, o_level_r = 0, o_empty = 1, o_req_rdy = 1, pointers = 0, gap_cnt = 0. FIFO contents are discarded and never issued.
- Reset mid-operation: in-flight o_upd_vld_r drops immediately on assertion; buffered requests are lost; first accepted request after deassertion behaves as from cold.
- Latency: request accepted at cycle t into empty FIFO, gap_cnt 0, no hold -> o_upd_vld_r high at t+2.
- Spacing: issues at cycles t and t' satisfy t' - t >= ISSUE_GAP; with a continuous backlog and no hold, exactly ISSUE_GAP.
- i_upd_hold high at cycle t blocks issue at t only; issue resumes the first cycle hold is low and the other conditions hold.
- o_level_r and o_empty are registered, updated the cycle after push/pop.

## Test plan

- Single request: rst_n released, push {prod_id=3, cmd=1, key=0x2A, size=5} at cycle 10 -> o_upd_vld_r high for cycle 12 only with matching payload; o_level_r 1 at 11, 0 at 12.
- Backlog spacing: ISSUE_GAP=3, push 4 requests back-to-back at cycles 10..13 -> o_upd_vld_r at 12, 15, 18, 21, in order; payload stable between pulses.
- Full/backpressure: FIFO_DEPTH=4, i_upd_hold=1, push 6 -> 4 accepted, o_req_rdy=0 after level hits 4; release hold -> o_req_rdy=1 the cycle after the first issue; the 5th request is issued 5th.
- Hold with gap: hold asserted 5 cycles during backlog -> no pulses during hold; first pulse 1 cycle after hold drops, then spacing 3; gap_cnt expiry unaffected by hold.
- Gap=1 streaming: ISSUE_GAP=1, continuous push every cycle -> o_upd_vld_r high every cycle, level steady at 1, no loss or reorder over 100 requests.
- Async reset mid-stream: assert rst_n between clock edges with 3 entries buffered -> o_upd_vld_r and payload 0 immediately, o_level_r 0; after release, no stale entries issued.
